// File: rtl/body_type_pkg.sv
// Shared constants and types for the body-type classifier slice.
package body_type_pkg;

    localparam logic [1:0] MODE_UNIFORM = 2'b00;
    localparam logic [1:0] MODE_ONES    = 2'b01;
    localparam logic [1:0] MODE_ZEROS   = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } run_state_t;

endpackage

// File: rtl/body_type_match.sv
// Combinational classify(code, mode): the single home of the body matching rule.
module body_type_match
    import body_type_pkg::*;
#(
    parameter int CODE_W = 3
) (
    input  logic [CODE_W-1:0] code,
    input  logic [1:0]        mode,
    output logic              body_type
);

    logic all_ones;
    logic all_zeros;

    assign all_ones  = &code;
    assign all_zeros = ~|code;

    always_comb begin
        body_type = 1'b0;
        case (mode)
            MODE_UNIFORM: body_type = all_ones | all_zeros;
            MODE_ONES:    body_type = all_ones;
            MODE_ZEROS:   body_type = all_zeros;
            default:      body_type = 1'b0;
        endcase
    end

endmodule

// File: rtl/body_type_classifier.sv
// Streaming body-type classifier: single-entry output register, type-1 run tracker,
// optional saturating type-1 counter enabled by `BODY_TYPE_STATS_EN.
module body_type_classifier
    import body_type_pkg::*;
#(
    parameter int CODE_W  = 3,
    parameter int RUN_LEN = 4
`ifdef BODY_TYPE_STATS_EN
    ,
    parameter int COUNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_type,
    output logic [CODE_W-1:0] out_code,
    output logic              run_hit
`ifdef BODY_TYPE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [COUNT_W-1:0] stat_count
`endif
);

    localparam int CNT_W = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

    logic             accept;
    logic             cls_type;
    run_state_t       state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign run_nxt  = run_cnt + CNT_W'(1);
    assign run_hit  = (state == HIT);

    body_type_match #(.CODE_W(CODE_W)) u_match (
        .code      (in_code),
        .mode      (mode),
        .body_type (cls_type)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_type  <= 1'b0;
            out_code  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_type  <= cls_type;
            out_code  <= in_code;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Run tracker only moves on accepted codes, so it stays aligned with out_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (cls_type) begin
                        run_cnt <= CNT_W'(1);
                        state   <= (RUN_LEN == 1) ? HIT : RUN;
                    end
                end
                RUN: begin
                    if (cls_type) begin
                        run_cnt <= run_nxt;
                        if (run_nxt == RUN_MAX) state <= HIT;
                    end else begin
                        run_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                HIT: begin
                    if (cls_type) begin
                        run_cnt <= RUN_MAX;
                    end else begin
                        run_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    run_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef BODY_TYPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count <= '0;
        end else if (stat_clr) begin
            stat_count <= '0;
        end else if (accept && cls_type && (stat_count != '1)) begin
            stat_count <= stat_count + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_body_type_classifier.sv
// Directed bench for body_type_classifier (CODE_W=3, RUN_LEN=4, COUNT_W=2 when stats built in).
module tb_body_type_classifier;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic       out_type;
    logic [2:0] out_code;
    logic       run_hit;
`ifdef BODY_TYPE_STATS_EN
    logic       stat_clr;
    logic [1:0] stat_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    body_type_classifier #(
        .CODE_W  (3),
        .RUN_LEN (4)
`ifdef BODY_TYPE_STATS_EN
        ,
        .COUNT_W (2)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_code  (out_code),
        .run_hit   (run_hit)
`ifdef BODY_TYPE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_count(stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] code;
        logic       typ;
        logic       hit;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one code with out_ready high; inputs change 1ns after an edge.
    task automatic send(input logic [1:0] m, input logic [2:0] c);
        mode     = m;
        in_code  = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 3'b000, 1'b1, 1'b0};
        vecs[1]  = '{2'b00, 3'b111, 1'b1, 1'b0};
        vecs[2]  = '{2'b00, 3'b101, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 3'b000, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 3'b000, 1'b1, 1'b0};
        vecs[5]  = '{2'b11, 3'b111, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 3'b111, 1'b1, 1'b0};
        vecs[7]  = '{2'b01, 3'b111, 1'b1, 1'b0};
        vecs[8]  = '{2'b10, 3'b000, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 3'b000, 1'b1, 1'b1};
        vecs[10] = '{2'b00, 3'b111, 1'b1, 1'b1};
        vecs[11] = '{2'b00, 3'b010, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 3'b111, 1'b1, 1'b0};
        vecs[13] = '{2'b01, 3'b111, 1'b1, 1'b0};
        vecs[14] = '{2'b01, 3'b111, 1'b1, 1'b0};
        vecs[15] = '{2'b00, 3'b010, 1'b0, 1'b0};
        vecs[16] = '{2'b00, 3'b011, 1'b0, 1'b0};

        rst_n     = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_code   = 3'b000;
        out_ready = 1'b1;
`ifdef BODY_TYPE_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_type",  32'(out_type),  32'd0);
        check("rst out_code",  32'(out_code),  32'd0);
        check("rst run_hit",   32'(run_hit),   32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
`ifdef BODY_TYPE_STATS_EN
        check("rst stat_count", 32'(stat_count), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream: each result must be present one edge after its accept.
        for (int i = 0; i < 17; i++) begin
            send(vecs[i].mode, vecs[i].code);
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d out_type", i),  32'(out_type),  32'(vecs[i].typ));
            check($sformatf("vec%0d out_code", i),  32'(out_code),  32'(vecs[i].code));
            check($sformatf("vec%0d run_hit", i),   32'(run_hit),   32'(vecs[i].hit));
        end
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: A held, B waits three cycles, then consume+refill in one edge.
        out_ready = 1'b0;
        send(2'b00, 3'b111);
        check("bp A valid", 32'(out_valid), 32'd1);
        mode     = 2'b00;
        in_code  = 3'b000;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp in_ready c%0d", k), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp hold code c%0d", k), 32'(out_code), 32'h7);
            check($sformatf("bp hold valid c%0d", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp B code",  32'(out_code),  32'h0);
        check("bp B valid", 32'(out_valid), 32'd1);
        check("bp B type",  32'(out_type),  32'd1);
        @(posedge clk);
        #1;
        check("bp drain valid", 32'(out_valid), 32'd0);
        send(2'b00, 3'b110);
        check("bp clear run", 32'(run_hit), 32'd0);

`ifdef BODY_TYPE_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check("stat cleared", 32'(stat_count), 32'd0);
        for (int k = 0; k < 5; k++) send(2'b00, 3'b111);
        check("stat saturate", 32'(stat_count), 32'd3);
        stat_clr = 1'b1;
        send(2'b00, 3'b000);
        stat_clr = 1'b0;
        check("stat clr wins", 32'(stat_count), 32'd0);
        send(2'b00, 3'b010);
`endif

        // Async reset while holding a HIT result.
        for (int k = 0; k < 4; k++) send(2'b00, 3'b000);
        check("pre-rst run_hit", 32'(run_hit), 32'd1);
        check("pre-rst valid",   32'(out_valid), 32'd1);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async out_type",  32'(out_type),  32'd0);
        check("async run_hit",   32'(run_hit),   32'd0);
        check("async in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2'b00, 3'b111);
        check("post-rst run_hit", 32'(run_hit), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/body_type_classifier.md
# body_type_classifier

Streaming, parametrised body-type classifier with a valid/ready handshake. Each accepted code of `CODE_W` bits is classified according to the selected mode and registered with one cycle of latency. The block also tracks runs of consecutive type-1 bodies and can optionally count type-1 bodies. It sits between the body-code source and the game-logic consumer, replacing the fixed 3-bit combinational classifier.

## Interface
- `CODE_W`, 3, width of body code; legal values ≥ 2
- `RUN_LEN`, 4, consecutive type-1 codes needed to raise `run_hit`; legal values ≥ 1
- `COUNT_W`, 16, width of the statistics counter (only with `BODY_TYPE_STATS_EN`)
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mode`  in  2  classification mode, sampled on each accepted code:
  - 00: uniform (all-zeros or all-ones)
  - 01: all-ones only
  - 10: all-zeros only
  - 11: disabled, type always 0
- `in_valid`  in  1  input code valid
- `in_ready`  out  1  block can accept a code
- `in_code`  in  CODE_W  body code
- `out_valid`  out  1  classified result valid
- `out_ready`  in  1  consumer accepts result
- `out_type`  out  1  1 = body matches the mode
- `out_code`  out  CODE_W  echo of the classified code
- `run_hit`  out  1  run of ≥ `RUN_LEN` type-1 codes in progress
- `stat_clr`  in  1  synchronous clear of `stat_count` (macro only)
- `stat_count`  out  COUNT_W  saturating count of type-1 codes (macro only)

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is a single-entry pipeline register; consume and refill in the same cycle is allowed.
- On accept, `out_code` ← `in_code`, `out_type` ← classify(`in_code`, `mode`), and `out_valid` ← 1.
- If no accept occurs and `out_ready` is high, `out_valid` ← 0.
- While `out_valid && !out_ready`, `out_code` and `out_type` hold stable.
- Run FSM (states IDLE, RUN, HIT) advances only on accept; `run_cnt` is `$clog2(RUN_LEN+1)` bits wide:
  - IDLE: type 1 → `run_cnt` = 1; go to HIT if `RUN_LEN` = 1, else RUN. Type 0 → stay in IDLE.
  - RUN: type 1 → `run_cnt`+1; go to HIT when it reaches `RUN_LEN`. Type 0 → IDLE, `run_cnt` = 0.
  - HIT: type 1 → stay, `run_cnt` saturates at `RUN_LEN`. Type 0 → IDLE, `run_cnt` = 0.
- `run_hit` = (state == HIT). It is registered and changes in the same cycle as the `out_*` fields of the code that caused the transition.
- A `mode` change between codes does not reset the FSM; each code is classified under the `mode` present at its own accept.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 code per cycle while `out_ready` is high.
- Reset values: `out_valid` 0, `out_type` 0, `out_code` 0, `run_hit` 0, FSM IDLE, `run_cnt` 0, `stat_count` 0.
- `in_ready` is 1 during reset (`out_valid` = 0).
- Reset asserted mid-stream discards the held result and clears all state immediately; there is no clock dependency.
- No combinational path from `in_valid` or `in_code` to any output. `in_ready` depends combinationally only on `out_valid` and `out_ready`.

## Configuration
- `BODY_TYPE_STATS_EN` defined:
  - `stat_clr` and `stat_count` exist.
  - `stat_count` increments on each accept with type 1 and saturates at 2^COUNT_W−1.
  - `stat_clr` wins over a simultaneous increment (result 0).
- Not defined: neither port exists, no counter logic is present, and all other behaviour is identical.

## Structure
- Shared package `body_type_pkg` holds:
  - mode constants `MODE_UNIFORM`, `MODE_ONES`, `MODE_ZEROS`, `MODE_OFF`
  - FSM state typedef `run_state_t` (IDLE, RUN, HIT)
- One sub-module, `body_type_match`: purely combinational classify(code, mode) → type, parametrised by `CODE_W`. It is the only place the matching rule lives.

## Test plan
- Reset, then with `CODE_W`=3 and mode 00, stream 000, 111, 101 with `out_ready`=1 → `out_type` 1, 1, 0, each one cycle after accept.
- Mode 01 with code 000 → `out_type` 0. Mode 10 with 000 → 1. Mode 11 with 111 → 0.
- `RUN_LEN`=4 with type-1 codes ×4, then 010 → `run_hit` rises with the 4th result and falls with the 010 result. Three type-1 codes then 010 → `run_hit` never rises.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and output stable. Release → the next code is accepted in the same cycle the held result is consumed, with no loss or duplication.
- Stats on, `COUNT_W`=2: 5 type-1 codes → `stat_count` 3 (saturated). Assert `stat_clr` together with a type-1 accept → 0.
- Pull `rst_n` low while `out_valid`=1 and FSM is in HIT → all outputs reach their reset values with no clock edge.
